pipeline_hazard_ctl: RTL

PIPELINE_HAZARD_CTL -- requirements
Module: pipeline_hazard_ctl

---
 rtl/pipeline_hazard_ctl_if.sv | 33 +++
 rtl/pipeline_hazard_ctl.sv | 93 +++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctl_if.sv
// Hazard-control bundle between the decode/memory side (master) and the
// hazard controller (slave).
interface pipeline_hazard_ctl_if;
  logic id_valid;
  logic stall_fetch;
  logic return_in_pipeline;
  logic halt;
  logic illegal_opcode_exception;
  logic ret_target_valid;
  logic mem_busy;
  logic irq_req;
  logic pc_stall;
  logic if_id_stall;
  logic if_id_flush;
  logic id_ex_flush;
  logic pipe_freeze;
  logic exc_ack;
  logic halted;

  modport master (
    output id_valid, stall_fetch, return_in_pipeline, halt,
           illegal_opcode_exception, ret_target_valid, mem_busy, irq_req,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze,
           exc_ack, halted
  );

  modport slave (
    input  id_valid, stall_fetch, return_in_pipeline, halt,
           illegal_opcode_exception, ret_target_valid, mem_busy, irq_req,
    output pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze,
           exc_ack, halted
  );
endinterface

// File: rtl/pipeline_hazard_ctl.sv
// Pipeline hazard controller: CALL/RET/exception/HALT sequencing with a
// memory-busy freeze overlay. Optional macro HALT_IRQ_WAKE_EN lets irq_req wake HALT.
module pipeline_hazard_ctl #(
  parameter int CALL_STALL_CYCLES = 2
) (
  input logic             clk,
  input logic             rst_n,
  pipeline_hazard_ctl_if.slave hz
);

  typedef enum logic [2:0] {RUN, CALL_WAIT, RET_WAIT, EXC, HALT} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(CALL_STALL_CYCLES - 1);

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic       wake;

  logic r_pc_stall, r_if_id_stall, r_if_id_flush, r_id_ex_flush;
  logic r_exc_ack, r_halted;
  logic busy;

`ifdef HALT_IRQ_WAKE_EN
  assign wake = hz.irq_req;
`else
  logic unused_irq;
  assign unused_irq = hz.irq_req;
  assign wake       = 1'b0;
`endif

  // A busy memory cycle freezes everything, so decode is only sampled when idle.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (!hz.mem_busy) begin
      case (state)
        RUN: begin
          if (hz.id_valid) begin
            if (hz.illegal_opcode_exception) state_d = EXC;
            else if (hz.halt)                state_d = HALT;
            else if (hz.return_in_pipeline)  state_d = RET_WAIT;
            else if (hz.stall_fetch) begin
              state_d = CALL_WAIT;
              cnt_d   = CNT_LOAD;
            end
          end
        end
        CALL_WAIT: begin
          if (cnt == 4'd0) state_d = RUN;
          else             cnt_d   = cnt - 4'd1;
        end
        RET_WAIT: if (hz.ret_target_valid) state_d = RUN;
        EXC:      state_d = RUN;
        HALT:     if (wake) state_d = RUN;
        default:  state_d = RUN;
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      cnt           <= 4'd0;
      r_pc_stall    <= 1'b0;
      r_if_id_stall <= 1'b0;
      r_if_id_flush <= 1'b0;
      r_id_ex_flush <= 1'b0;
      r_exc_ack     <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      r_pc_stall    <= state_d inside {CALL_WAIT, RET_WAIT, HALT};
      r_if_id_stall <= state_d inside {CALL_WAIT, HALT};
      r_if_id_flush <= state_d inside {RET_WAIT, EXC};
      r_id_ex_flush <= state_d inside {EXC, HALT};
      r_exc_ack     <= state_d == EXC;
      r_halted      <= state_d == HALT;
    end
  end

  // Reset must silence the busy overlay too, hence the rst_n qualifier.
  assign busy            = hz.mem_busy & rst_n;
  assign hz.pipe_freeze  = busy;
  assign hz.pc_stall     = r_pc_stall | busy;
  assign hz.if_id_flush  = r_if_id_flush & ~busy;
  assign hz.if_id_stall  = (r_if_id_stall | busy) & ~hz.if_id_flush;
  assign hz.id_ex_flush  = r_id_ex_flush & ~busy;
  assign hz.exc_ack      = r_exc_ack & ~busy;
  assign hz.halted       = r_halted;

endmodule
